// File: rtl/avg_pool_controller.sv
// 2x2 average-pooling controller: streams each 2x2 window of an img_side x img_side
// image out of a pixel buffer and writes the truncated mean into a pooled buffer.
module avg_pool_controller #(
  parameter int unsigned resolution = 8,
  parameter int unsigned img_side   = 28,
  parameter int unsigned in_addr_w  = 10,
  parameter int unsigned out_addr_w = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [in_addr_w-1:0]  rd_addr,
  input  logic [resolution-1:0] rd_data,
  output logic                  wr_en,
  output logic [out_addr_w-1:0] wr_addr,
  output logic [resolution-1:0] wr_data
);

  localparam int unsigned out_side = img_side / 2;
  localparam int unsigned n_win    = out_side * out_side;
  localparam int unsigned cnt_w    = (out_side > 1) ? $clog2(out_side) : 1;
  localparam int unsigned acc_w    = resolution + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LAST  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  state, state_n;
  logic [1:0]              k, k_n;
  logic [cnt_w-1:0]        orow, orow_n;
  logic [cnt_w-1:0]        ocol, ocol_n;
  logic [out_addr_w-1:0]   win, win_n;
  logic [acc_w-1:0]        acc, acc_n;
  logic [in_addr_w-1:0]    row_n, col_n;

  logic                    busy_d, done_d, rd_en_d, wr_en_d;
  logic [in_addr_w-1:0]    rd_addr_d;
  logic [out_addr_w-1:0]   wr_addr_d;
  logic [resolution-1:0]   wr_data_d;

  // State, counters, accumulator and all outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      orow    <= '0;
      ocol    <= '0;
      win     <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      k       <= k_n;
      orow    <= orow_n;
      ocol    <= ocol_n;
      win     <= win_n;
      acc     <= acc_n;
      busy    <= busy_d;
      done    <= done_d;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
    end
  end

  // Next state plus the values the output registers take in the next cycle.
  always_comb begin
    state_n   = state;
    k_n       = k;
    orow_n    = orow;
    ocol_n    = ocol;
    win_n     = win;
    acc_n     = acc;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          k_n     = '0;
          orow_n  = '0;
          ocol_n  = '0;
          win_n   = '0;
          acc_n   = '0;
        end
      end
      FETCH: begin
        // Read data trails rd_en by one cycle, so k=0 has nothing to add yet.
        k_n = k + 2'd1;
        if (k != 2'd0) begin
          acc_n = acc + acc_w'(rd_data);
        end
        if (k == 2'd3) begin
          state_n = LAST;
        end
      end
      LAST: begin
        acc_n   = acc + acc_w'(rd_data);
        state_n = WRITE;
      end
      WRITE: begin
        k_n   = '0;
        acc_n = '0;
        if (win == out_addr_w'(n_win - 1)) begin
          state_n = DONE;
        end else begin
          state_n = FETCH;
          win_n   = win + out_addr_w'(1);
          if (ocol == cnt_w'(out_side - 1)) begin
            ocol_n = '0;
            orow_n = orow + cnt_w'(1);
          end else begin
            ocol_n = ocol + cnt_w'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Pixel coordinates of window element k: (2*orow + k[1], 2*ocol + k[0]).
    row_n = in_addr_w'({orow_n, 1'b0}) + in_addr_w'(k_n[1]);
    col_n = in_addr_w'({ocol_n, 1'b0}) + in_addr_w'(k_n[0]);

    busy_d  = (state_n == FETCH) || (state_n == LAST) || (state_n == WRITE);
    done_d  = (state_n == DONE);
    rd_en_d = (state_n == FETCH);
    wr_en_d = (state_n == WRITE);
    if (state_n == FETCH) begin
      rd_addr_d = row_n * in_addr_w'(img_side) + col_n;
    end
    if (state_n == WRITE) begin
      wr_addr_d = win_n;
      wr_data_d = acc_n[acc_w-1:2];
    end
  end

endmodule
